// File: rtl/upsampler_mc_pkg.sv
// Shared constants for the multi-channel integer-factor upsampler.
// Holds the controller state encoding, the pad-mode encoding and the pad sample value.
// Optional feature macro: UPSAMPLER_MC_HOLD_EN (sample-and-hold pads).
package upsampler_mc_pkg;

    typedef enum logic {
        UPS_IDLE   = 1'b0,
        UPS_ACTIVE = 1'b1
    } ups_state_e;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    // Pad samples are all-zeros. This bit is replicated to the full datapath width.
    localparam logic PAD_BIT = 1'b0;

endpackage

// File: rtl/upsampler_mc_phase_ctr.sv
// Phase counter for the upsampler.
// Counts output phases 0..rate_i-1 while active. A load restarts it at phase 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : symbol accepted; the next cycle is phase 0
//   active_i  : controller is emitting samples
//   rate_i    : registered upsample factor (never 0)
//   phase_o   : current phase
//   last_o    : current phase is rate_i-1 (terminal count)
module upsampler_mc_phase_ctr #(
    parameter int unsigned RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              active_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic [RATE_W-1:0] phase_o,
    output logic              last_o
);

    logic [RATE_W-1:0] phase_q, phase_d;

    assign phase_o = phase_q;
    assign last_o  = (phase_q == (rate_i - RATE_W'(1)));

    // Terminal count without a load returns to 0 so the idle phase is always 0.
    always_comb begin
        phase_d = phase_q;
        if (load_i) begin
            phase_d = '0;
        end else if (active_i && !last_o) begin
            phase_d = phase_q + RATE_W'(1);
        end else begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/upsampler_mc.sv
// Multi-channel integer-factor upsampler.
// Accepts one symbol (all channels in parallel) per valid/ready handshake and emits R samples,
// one per clock: the symbol, then R-1 pads. Output appears one clock after acceptance.
// Optional feature macro: UPSAMPLER_MC_HOLD_EN -- when defined, mode=1 repeats the symbol on
// pad phases; when undefined, mode is ignored and pads are zero.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   sample_rate  : upsample factor R (0 treated as 1), sampled on acceptance
//   mode         : 0 zero-pad, 1 sample-and-hold
//   in_valid     : symbol present on in_data
//   in_ready     : symbol can be accepted this cycle
//   in_data      : NUM_CH samples, channel 0 in LSBs
//   out_valid    : out_data is a live sample
//   out_data     : upsampled output, channel 0 in LSBs
//   out_first    : this sample is the real symbol (phase 0)
module upsampler_mc
    import upsampler_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned RATE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RATE_W-1:0]        sample_rate,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_first
);

    localparam int unsigned W = NUM_CH * DATA_W;

    ups_state_e        state_q, state_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [W-1:0]      hold_q, hold_d;
    logic [RATE_W-1:0] phase;
    logic              last;
    logic              accept;
    logic              active;
    logic              pad_hold;

    assign active   = (state_q == UPS_ACTIVE);
    // Ready depends only on registered state so the mapper never sees a valid->ready path.
    assign in_ready = !active || last;
    assign accept   = in_valid && in_ready;

`ifdef UPSAMPLER_MC_HOLD_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (accept) begin
            mode_d = mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_ZERO;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign pad_hold = (mode_q == MODE_HOLD);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign pad_hold    = 1'b0;
`endif

    upsampler_mc_phase_ctr #(
        .RATE_W (RATE_W)
    ) u_phase_ctr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .active_i (active),
        .rate_i   (rate_q),
        .phase_o  (phase),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d = UPS_ACTIVE;
            rate_d  = (sample_rate == '0) ? RATE_W'(1) : sample_rate;
            hold_d  = in_data;
        end else if (active && last) begin
            state_d = UPS_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UPS_IDLE;
            rate_q  <= RATE_W'(1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs decode only registered state, so reset clears them immediately.
    always_comb begin
        out_valid = active;
        out_first = 1'b0;
        out_data  = {W{PAD_BIT}};
        if (active) begin
            if (phase == '0) begin
                out_first = 1'b1;
                out_data  = hold_q;
            end else if (pad_hold) begin
                out_data  = hold_q;
            end
        end
    end

endmodule

// File: tb/tb_upsampler_mc.sv
// Self-checking bench for upsampler_mc. A queue-based model turns every accepted symbol into
// its R expected samples; ready is expected exactly when no samples remain queued beyond the
// current one.
module tb_upsampler_mc;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned RATE_W = 4;
    localparam int unsigned W      = NUM_CH * DATA_W;
    localparam int unsigned VW     = W + 3;

`ifdef UPSAMPLER_MC_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [RATE_W-1:0] sample_rate = '0;
    logic              mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_first;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         first;
        logic [W-1:0] data;
    } item_t;

    item_t exp_q[$];
    logic  model_ready = 1'b1;

    always #5 clk = ~clk;

    upsampler_mc #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .RATE_W (RATE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_rate (sample_rate),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_first   (out_first)
    );

    // Drive one cycle of inputs, advance the model across the edge, and return the observed
    // and expected {valid, first, ready, data} for the following cycle.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [RATE_W-1:0] r,
                        input logic m, output logic [VW-1:0] obs, output logic [VW-1:0] exp);
        logic  acc;
        int    rr;
        item_t it;
        logic  ev;
        in_valid    = v;
        in_data     = d;
        sample_rate = r;
        mode        = m;
        acc = v && model_ready;
        @(posedge clk);
        if (acc) begin
            rr = (r == 0) ? 1 : int'(r);
            exp_q.push_back('{first: 1'b1, data: d});
            for (int k = 1; k < rr; k++) begin
                exp_q.push_back('{first: 1'b0, data: (HOLD_EN && m) ? d : '0});
            end
        end
        #1;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            ev = 1'b1;
        end else begin
            it = '{first: 1'b0, data: '0};
            ev = 1'b0;
        end
        model_ready = (exp_q.size() == 0);
        obs = {out_valid, out_first, in_ready, out_data};
        exp = {ev, it.first, model_ready, it.data};
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        exp_q.delete();
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs = {out_valid, out_first, in_ready, out_data};
        exp = {1'b0, 1'b0, 1'b1, {W{1'b0}}};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, exp);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_ready = 1'b1;
    endtask

    task automatic test_single();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 8'hA5, 4'd4, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single cyc%0d: got %h want %h", i + 1, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        logic [W-1:0]  syms [3];
        int            idx = 0;
        syms[0] = 8'h11;
        syms[1] = 8'h22;
        syms[2] = 8'h33;
        for (int i = 0; i < 11; i++) begin
            step(idx < 3, (idx < 3) ? syms[idx] : '0, 4'd3, 1'b0, obs, exp);
            if (exp[VW-3]) idx++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 1; i <= 10; i++) begin
            step(i <= 8, W'(i), RATE_W'(i % 2), 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL passthru cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_rate_change();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 0; i < 9; i++) begin
            step(i == 0 || i == 4, (i == 0) ? 8'h7E : 8'h3C, (i == 0) ? 4'd4 : 4'd2, 1'b0,
                 obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rate_change cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 8'h5C, 4'd3, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL hold cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 8'hC3, 4'd8, 1'b0, obs, exp);
        end
        // Now in phase 2; reset between edges must clear the outputs at once.
        rst = 1'b1;
        #1;
        obs = {out_valid, out_first, in_ready, out_data};
        exp = {1'b0, 1'b0, 1'b1, {W{1'b0}}};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid async: got %h want %h", obs, exp);
        end
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 8'h96, 4'd2, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid after cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, W'($urandom), RATE_W'($urandom_range(0, 5)),
                 1'($urandom), obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs, exp);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random drain%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_passthrough();
        test_rate_change();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
